// File: rtl/alu_unit_if.sv
// -----------------------------------------------------------------------------
// alu_unit_if
//   Operand/handshake/result bundle between the register set (master) and the
//   ALU stage (slave).
//   Master drives: i_a, i_b (operands), i_op (opcode), i_start (start request).
//   Slave drives : o_busy (multiply in progress), o_done (one-cycle completion
//                  pulse), o_result (registered result), o_flags ({V,N,Z,C}).
// -----------------------------------------------------------------------------
interface alu_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [3:0]       i_op;
    logic             i_start;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic [3:0]       o_flags;

    modport master (
        output i_a, i_b, i_op, i_start,
        input  o_busy, o_done, o_result, o_flags
    );

    modport slave (
        input  i_a, i_b, i_op, i_start,
        output o_busy, o_done, o_result, o_flags
    );
endinterface

// File: rtl/alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
//   ALU stage downstream of the register set. Single-cycle add/sub/logic/shift
//   operations plus an optional shift-add multiplier (WIDTH iterations) with a
//   busy/done handshake. Result and flags ({V,N,Z,C}) are registered; the result
//   is driven back onto the shared bus through a tri-state transmitter.
//
//   Build option: define ALU_MUL_EN to build the multiplier (opcodes 11 MUL and
//   12 MULH). Without it those opcodes act as reserved and o_busy is tied 0.
//
//   Ports:
//     i_clk    clock (rising edge)
//     i_reset  synchronous, active-high reset (aborts an in-flight multiply)
//     bus_if   alu_unit_if.slave: operands, opcode, start, busy, done,
//              result, flags
//     i_busEn  enables the tri-state bus driver
//     o_bus    result onto the shared bus, high-Z when i_busEn=0
// -----------------------------------------------------------------------------

// Tri-state bus driver: passes i_d when i_ce is high, otherwise floats.
module transmitter #(
    parameter int WIDTH = 8
) (
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_d,
    output tri   [WIDTH-1:0] o_q
);
    assign o_q = i_ce ? i_d : {WIDTH{1'bz}};
endmodule

module alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    alu_unit_if.slave        bus_if,
    input  logic             i_busEn,
    output tri   [WIDTH-1:0] o_bus
);
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ROR = 4'd10;

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {v, r[WIDTH-1], (r == '0), c};
    endfunction

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q,  flags_d;
    logic             done_q,   done_d;
    logic             busy_w;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_upd;

    always_comb begin
        // SUB/SBC add the inverted operand; carry-in is 1 for SUB, the stored
        // C flag for ADC/SBC (C=1 means "no borrow" on subtract).
        b_eff = (bus_if.i_op == OP_SUB || bus_if.i_op == OP_SBC) ? ~bus_if.i_b : bus_if.i_b;
        if (bus_if.i_op == OP_ADD)      cin = 1'b0;
        else if (bus_if.i_op == OP_SUB) cin = 1'b1;
        else                            cin = flags_q[0];
        sum = {1'b0, bus_if.i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

        alu_upd = 1'b1;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus_if.i_op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Overflow: both addends share a sign that the sum does not.
                alu_v   = (bus_if.i_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus_if.i_a[WIDTH-1]);
            end
            OP_AND: alu_res = bus_if.i_a & bus_if.i_b;
            OP_OR:  alu_res = bus_if.i_a | bus_if.i_b;
            OP_XOR: alu_res = bus_if.i_a ^ bus_if.i_b;
            OP_NOT: alu_res = ~bus_if.i_a;
            OP_SHL: begin
                alu_res = {bus_if.i_a[WIDTH-2:0], 1'b0};
                alu_c   = bus_if.i_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus_if.i_a[WIDTH-1:1]};
                alu_c   = bus_if.i_a[0];
            end
            OP_ROR: begin
                alu_res = {flags_q[0], bus_if.i_a[WIDTH-1:1]};
                alu_c   = bus_if.i_a[0];
            end
            default: alu_upd = 1'b0;   // reserved (and MUL/MULH when not built)
        endcase
    end

`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_MULH = 4'd12;
    localparam int         CNT_W   = $clog2(WIDTH + 1);

    logic                   busy_q,   busy_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]     mcand_q,  mcand_d;   // multiplicand, shifts left
    logic [WIDTH-1:0]       mplier_q, mplier_d;  // multiplier, shifts right
    logic [2*WIDTH-1:0]     prod_q,   prod_d;
    logic                   mulh_q,   mulh_d;
    logic [2*WIDTH-1:0]     prod_step;

    assign busy_w    = busy_q;
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign busy_w = 1'b0;
`endif

    // ---------------- next-state ----------------
    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
`ifdef ALU_MUL_EN
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mulh_d   = mulh_q;
`endif
        if (bus_if.i_start && !busy_w) begin
`ifdef ALU_MUL_EN
            if (bus_if.i_op == OP_MUL || bus_if.i_op == OP_MULH) begin
                // Operands are captured here so the source may move on.
                busy_d   = 1'b1;
                cnt_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, bus_if.i_a};
                mplier_d = bus_if.i_b;
                prod_d   = '0;
                mulh_d   = (bus_if.i_op == OP_MULH);
            end else
`endif
            begin
                done_d = 1'b1;
                if (alu_upd) begin
                    result_d = alu_res;
                    flags_d  = pack_flags(alu_res, alu_c, alu_v);
                end
            end
        end
`ifdef ALU_MUL_EN
        else if (busy_q) begin
            prod_d   = prod_step;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                // Last iteration: prod_step holds the full product.
                busy_d = 1'b0;
                done_d = 1'b1;
                if (mulh_q) begin
                    result_d = prod_step[2*WIDTH-1:WIDTH];
                    flags_d  = pack_flags(prod_step[2*WIDTH-1:WIDTH],
                                          |prod_step[WIDTH-1:0], 1'b0);
                end else begin
                    result_d = prod_step[WIDTH-1:0];
                    flags_d  = pack_flags(prod_step[WIDTH-1:0],
                                          |prod_step[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            mulh_q   <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            mulh_q   <= mulh_d;
`endif
        end
    end

    assign bus_if.o_result = result_q;
    assign bus_if.o_flags  = flags_q;
    assign bus_if.o_done   = done_q;
    assign bus_if.o_busy   = busy_w;

    transmitter #(.WIDTH(WIDTH)) u_tx (
        .i_ce (i_busEn),
        .i_d  (result_q),
        .o_q  (o_bus)
    );
endmodule
